// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;

  localparam logic [7:0] SyncByteDefault = 8'hA5;
  localparam int unsigned ByteW  = 8;
  localparam int unsigned WordW  = 16;
  // Word count spans 1..256, so one bit wider than the count byte.
  localparam int unsigned CountW = 9;

  typedef enum logic [3:0] {
    StIdle,
    StSync,
    StCount,
    StHi,
    StLo,
    StWrite,
    StCheck,
    StDone,
    StError
  } load_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling, one-cycle byte strobe.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic             byte_valid,
  output logic [ByteW-1:0] byte_data,
  output logic             frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [ByteW-1:0] shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = RxStart;
      end
      RxStart: begin
        if (cnt_q == CntW'(CLKS_PER_BIT / 2 - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[ByteW-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          ferr_d  = ~rx_sync_q;
          state_d = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/cpu_prog_loader.sv
// Serial program loader: frames UART bytes into 16-bit words, writes imem, gates the CPU.
module cpu_prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned ADDR_W       = 8,
  parameter logic [7:0]  SYNC_BYTE    = SyncByteDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              load_en,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WordW-1:0]  imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              load_err
);

  logic             byte_valid, frame_err;
  logic [ByteW-1:0] byte_data;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  load_state_e       state_q, state_d;
  logic [CountW-1:0] words_q, words_d;
  logic [ByteW-1:0]  hi_q, hi_d, lo_q, lo_d, csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WordW-1:0]  wdata_q, wdata_d;
  logic              hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic              in_frame;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      words_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_frame = (state_q == StCount) || (state_q == StHi) || (state_q == StLo) ||
                    (state_q == StWrite) || (state_q == StCheck);

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    // Address advances the cycle after the strobe so it is stable during the write.
    addr_d  = we_q ? addr_q + ADDR_W'(1) : addr_q;

    if (in_frame && !load_en) begin
      state_d = StIdle;
      err_d   = 1'b1;
      hold_d  = 1'b0;
    end else if (in_frame && byte_valid && frame_err) begin
      state_d = StError;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: if (load_en) state_d = StSync;
        StSync: begin
          if (!load_en) begin
            state_d = StIdle;
          end else if (byte_valid && !frame_err && byte_data == SYNC_BYTE) begin
            state_d = StCount;
            hold_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            addr_d  = '0;
            csum_d  = '0;
          end
        end
        StCount: begin
          if (byte_valid) begin
            words_d = (byte_data == '0) ? CountW'(256) : {1'b0, byte_data};
            state_d = StHi;
          end
        end
        StHi: begin
          if (byte_valid) begin
            hi_d    = byte_data;
            csum_d  = csum_q ^ byte_data;
            state_d = StLo;
          end
        end
        StLo: begin
          if (byte_valid) begin
            lo_d    = byte_data;
            csum_d  = csum_q ^ byte_data;
            state_d = StWrite;
          end
        end
        StWrite: begin
          we_d    = 1'b1;
          wdata_d = {hi_q, lo_q};
          if (words_q > CountW'(1)) begin
            words_d = words_q - CountW'(1);
            state_d = StHi;
          end else begin
            state_d = StCheck;
          end
        end
        StCheck: begin
          if (byte_valid) begin
            if (byte_data == csum_q) begin
              state_d = StDone;
              done_d  = 1'b1;
              hold_d  = 1'b0;
            end else begin
              state_d = StError;
              err_d   = 1'b1;
            end
          end
        end
        StDone: if (!load_en) state_d = StIdle;
        StError: begin
          if (!load_en) begin
            state_d = StIdle;
            hold_d  = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed bench for cpu_prog_loader: a 16-clk/bit instance for framing cases, a 4-clk/bit one for N=0.
module tb_cpu_prog_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx16 = 1'b1, rx4 = 1'b1;
  logic en16 = 1'b0, en4 = 1'b0;

  logic        we16, hold16, done16, err16;
  logic [7:0]  addr16;
  logic [15:0] wdata16;
  logic        we4, hold4, done4, err4;
  logic [7:0]  addr4;
  logic [15:0] wdata4;

  always #5 clk = ~clk;

  cpu_prog_loader #(.CLKS_PER_BIT(16), .ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx(rx16), .load_en(en16),
    .imem_we(we16), .imem_addr(addr16), .imem_wdata(wdata16),
    .cpu_hold(hold16), .done(done16), .load_err(err16)
  );

  cpu_prog_loader #(.CLKS_PER_BIT(4), .ADDR_W(8), .SYNC_BYTE(8'hA5)) dut4 (
    .clk(clk), .reset(reset), .rx(rx4), .load_en(en4),
    .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
    .cpu_hold(hold4), .done(done4), .load_err(err4)
  );

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  b [10];
    int          n;
    int          bad_idx;
    int          n_wr;
    int          lo_idx;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        exp_done;
    logic        exp_err;
    logic        exp_hold;
  } vec_t;

  int   cyc = 0;
  int   total = 0, bad = 0;
  int   last_start;
  int   starts [10];
  int   we_long, done_rise;
  logic we16_prev = 1'b0, done16_prev = 1'b0;
  wr_t  wq16 [$];
  wr_t  wq4 [$];
  vec_t vt [5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we16) wq16.push_back('{cyc, addr16, wdata16});
    if (we16 && we16_prev) we_long++;
    if (done16 && !done16_prev) done_rise = cyc;
    we16_prev   = we16;
    done16_prev = done16;
    if (we4) wq4.push_back('{cyc, addr4, wdata4});
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input bit fast, input logic [7:0] b, input bit bad_stop);
    int         cpb;
    logic [9:0] frame;
    cpb   = fast ? 4 : 16;
    frame = {~bad_stop, b, 1'b0};
    @(posedge clk); #1;
    last_start = cyc;
    for (int i = 0; i < 10; i++) begin
      if (fast) rx4 = frame[i];
      else rx16 = frame[i];
      repeat (cpb) @(posedge clk);
      #1;
    end
    if (fast) rx4 = 1'b1;
    else rx16 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] csum, hi, lo;
    int         errs;

    // Checksum is the XOR of the data bytes: 12^34^AB^CD = 40.
    vt[0] = '{'{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00},
              7, -1, 2, 3, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0};
    vt[1] = '{'{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00},
              7, -1, 2, 3, 16'h1234, 16'hABCD, 1'b0, 1'b1, 1'b1};
    vt[2] = '{'{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h07, 8'h07, 8'h00, 8'h00, 8'h00},
              7, -1, 1, 5, 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[3] = '{'{8'hA5, 8'h02, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              4, 3, 0, 3, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
    vt[4] = '{'{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00},
              9, -1, 3, 3, 16'h0102, 16'h0304, 1'b1, 1'b0, 1'b0};

    wait_cyc(3);
    @(negedge clk);
    chk("rst_we", 32'(we16), 0);
    chk("rst_addr", 32'(addr16), 0);
    chk("rst_wdata", 32'(wdata16), 0);
    chk("rst_hold", 32'(hold16), 0);
    chk("rst_done", 32'(done16), 0);
    chk("rst_err", 32'(err16), 0);
    reset = 1'b0;
    wait_cyc(2);

    for (int v = 0; v < 5; v++) begin
      en16 = 1'b1;
      wait_cyc(3);
      if (v == 2) begin
        rx16 = 1'b0;
        wait_cyc(3);
        rx16 = 1'b1;
        wait_cyc(40);
      end
      wq16.delete();
      we_long   = 0;
      done_rise = -1;
      for (int k = 0; k < vt[v].n; k++) begin
        send_byte(1'b0, vt[v].b[k], k == vt[v].bad_idx);
        starts[k] = last_start;
      end
      wait_cyc(10);
      @(negedge clk);
      chk($sformatf("v%0d_nwrites", v), wq16.size(), vt[v].n_wr);
      if (vt[v].n_wr > 0 && wq16.size() > 0) begin
        chk($sformatf("v%0d_addr0", v), 32'(wq16[0].addr), 0);
        chk($sformatf("v%0d_data0", v), 32'(wq16[0].data), 32'(vt[v].d0));
        chk($sformatf("v%0d_we_lat0", v), wq16[0].cyc - starts[vt[v].lo_idx], 157);
      end
      if (vt[v].n_wr > 1 && wq16.size() > 1) begin
        chk($sformatf("v%0d_addr1", v), 32'(wq16[1].addr), 1);
        chk($sformatf("v%0d_data1", v), 32'(wq16[1].data), 32'(vt[v].d1));
        chk($sformatf("v%0d_we_lat1", v), wq16[1].cyc - starts[vt[v].lo_idx + 2], 157);
      end
      chk($sformatf("v%0d_we_width", v), we_long, 0);
      chk($sformatf("v%0d_done", v), 32'(done16), 32'(vt[v].exp_done));
      chk($sformatf("v%0d_err", v), 32'(err16), 32'(vt[v].exp_err));
      chk($sformatf("v%0d_hold", v), 32'(hold16), 32'(vt[v].exp_hold));
      if (vt[v].exp_done)
        chk($sformatf("v%0d_done_lat", v), done_rise - starts[vt[v].n - 1], 156);
      en16 = 1'b0;
      wait_cyc(3);
      @(negedge clk);
      chk($sformatf("v%0d_hold_off", v), 32'(hold16), 0);
      chk($sformatf("v%0d_err_sticky", v), 32'(err16), 32'(vt[v].exp_err));
    end

    // Abort after the high byte of the first word.
    en16 = 1'b1;
    wait_cyc(3);
    wq16.delete();
    send_byte(1'b0, 8'hA5, 1'b0);
    send_byte(1'b0, 8'h01, 1'b0);
    send_byte(1'b0, 8'h12, 1'b0);
    en16 = 1'b0;
    wait_cyc(2);
    @(negedge clk);
    chk("abort_err", 32'(err16), 1);
    chk("abort_hold", 32'(hold16), 0);
    chk("abort_done", 32'(done16), 0);
    chk("abort_nwrites", wq16.size(), 0);

    // Reset in the middle of a byte, then a clean load.
    en16 = 1'b1;
    wait_cyc(3);
    send_byte(1'b0, 8'hA5, 1'b0);
    send_byte(1'b0, 8'h02, 1'b0);
    send_byte(1'b0, 8'h12, 1'b0);
    rx16 = 1'b0;
    wait_cyc(40);
    chk("mid_hold", 32'(hold16), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    rx16 = 1'b1;
    @(negedge clk);
    chk("mrst_we", 32'(we16), 0);
    chk("mrst_addr", 32'(addr16), 0);
    chk("mrst_wdata", 32'(wdata16), 0);
    chk("mrst_hold", 32'(hold16), 0);
    chk("mrst_done", 32'(done16), 0);
    chk("mrst_err", 32'(err16), 0);
    reset = 1'b0;
    wait_cyc(40);
    wq16.delete();
    for (int k = 0; k < 7; k++) send_byte(1'b0, vt[0].b[k], 1'b0);
    wait_cyc(10);
    @(negedge clk);
    chk("post_rst_nwrites", wq16.size(), 2);
    chk("post_rst_done", 32'(done16), 1);
    chk("post_rst_hold", 32'(hold16), 0);
    en16 = 1'b0;

    // Count byte 0 means 256 words; addresses run 0..255.
    en4 = 1'b1;
    wait_cyc(3);
    wq4.delete();
    csum = 8'h00;
    send_byte(1'b1, 8'hA5, 1'b0);
    send_byte(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i);
      lo = 8'(i * 3);
      csum = csum ^ hi ^ lo;
      send_byte(1'b1, hi, 1'b0);
      send_byte(1'b1, lo, 1'b0);
    end
    send_byte(1'b1, csum, 1'b0);
    wait_cyc(10);
    @(negedge clk);
    chk("c0_nwrites", wq4.size(), 256);
    errs = 0;
    for (int i = 0; i < wq4.size(); i++) begin
      if (wq4[i].addr !== 8'(i) || wq4[i].data !== {8'(i), 8'(i * 3)}) errs++;
    end
    chk("c0_addr_data_errs", errs, 0);
    chk("c0_done", 32'(done4), 1);
    chk("c0_hold", 32'(hold4), 0);
    chk("c0_err", 32'(err4), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
